// File: rtl/led_pulse_driver.sv
// Event-driven LED blinker: each accepted event produces one ON/OFF blink of fixed tick lengths.
// Latency: led rises the cycle after event_i is sampled in IDLE; outputs are registered.
// Backpressure: none on event_i; events arriving mid-blink queue in pend (LED_PULSE_QUEUE_EN) and saturate, or are dropped.
module led_pulse_driver #(
    parameter int PRESCALE  = 128,
    parameter int ON_TICKS  = 4,
    parameter int OFF_TICKS = 4,
    parameter int QW        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          event_i,
    output logic          led,
    output logic          busy,
    output logic [QW-1:0] pend
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam logic [10:0] PRESC_LAST = 11'(PRESCALE - 1);
    localparam logic [7:0]  ON_LAST    = 8'(ON_TICKS - 1);
    localparam logic [7:0]  OFF_LAST   = 8'(OFF_TICKS - 1);

    state_t      state_q, state_d;
    logic [10:0] presc_q, presc_d;
    logic [7:0]  tick_q, tick_d;
    logic        led_q, busy_q;

    logic tick_w;
    logic on_end;
    logic off_end;
    logic has_pend;

    // A tick fires on the last prescaler count of any active state.
    assign tick_w  = (state_q != IDLE) && (presc_q == PRESC_LAST);
    assign on_end  = (state_q == ON)  && tick_w && (tick_q == ON_LAST);
    assign off_end = (state_q == OFF) && tick_w && (tick_q == OFF_LAST);

`ifdef LED_PULSE_QUEUE_EN
    localparam logic [QW-1:0] PEND_MAX = '1;

    logic [QW-1:0] pend_q, pend_d;
    logic          consume;
    logic          pend_inc;
    logic          pend_dec;

    assign has_pend = (pend_q != '0);
    // An event landing exactly on OFF end with an empty queue starts the next blink directly.
    assign consume  = off_end && event_i && !has_pend;
    assign pend_inc = (state_q != IDLE) && event_i && !consume;
    assign pend_dec = off_end && has_pend;

    // Queue depth: simultaneous enqueue and dequeue cancel; enqueue saturates at full.
    always_comb begin
        pend_d = pend_q;
        if (pend_inc && !pend_dec) begin
            if (pend_q != PEND_MAX) begin
                pend_d = pend_q + QW'(1);
            end
        end else if (pend_dec && !pend_inc) begin
            pend_d = pend_q - QW'(1);
        end
    end

    // Queue register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;
`else
    assign has_pend = 1'b0;
    assign pend     = '0;
`endif

    // Next-state, prescaler and tick counter; both counters restart on every state entry.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = tick_q;

        case (state_q)
            IDLE: begin
                if (event_i) begin
                    state_d = ON;
                end
            end
            ON: begin
                if (on_end) begin
                    state_d = OFF;
                end
            end
            OFF: begin
                if (off_end) begin
                    if (has_pend || event_i) begin
                        state_d = ON;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            presc_d = '0;
            tick_d  = '0;
        end else if (state_q != IDLE) begin
            if (tick_w) begin
                presc_d = '0;
                tick_d  = tick_q + 8'd1;
            end else begin
                presc_d = presc_q + 11'd1;
            end
        end
    end

    // State, counters and registered outputs; led/busy follow the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            tick_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            led_q   <= (state_d == ON);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign led  = led_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_led_pulse_driver.sv
// Directed bench for led_pulse_driver with PRESCALE=4, ON_TICKS=2, OFF_TICKS=3, QW=2 (ON=8, OFF=12 cycles).
// Traces are captured #1 after each rising edge; obs[c] is the state during cycle c.
// Queue scenarios check the queued behaviour when LED_PULSE_QUEUE_EN is defined, else the drop behaviour.
module tb_led_pulse_driver;

    logic       clk;
    logic       rst;
    logic       event_i;
    logic       led;
    logic       busy;
    logic [1:0] pend;

    int n_checks = 0;
    int n_pass   = 0;

    logic       ev      [0:127];
    logic       rs      [0:127];
    logic       led_tr  [0:127];
    logic       busy_tr [0:127];
    logic [1:0] pend_tr [0:127];

    led_pulse_driver #(
        .PRESCALE (4),
        .ON_TICKS (2),
        .OFF_TICKS(3),
        .QW       (2)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .event_i(event_i),
        .led    (led),
        .busy   (busy),
        .pend   (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_stim();
        for (int i = 0; i < 128; i++) begin
            ev[i] = 1'b0;
            rs[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        event_i = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    // Drive ev/rs for cycles 0..n-1 and record outputs seen in cycles 1..n.
    task automatic run_trace(input int n);
        for (int c = 0; c < n; c++) begin
            rst     = rs[c];
            event_i = ev[c];
            @(posedge clk);
            #1;
            led_tr[c+1]  = led;
            busy_tr[c+1] = busy;
            pend_tr[c+1] = pend;
        end
        rst     = 1'b0;
        event_i = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        event_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({led, busy, pend} !== 4'b0000)
                $display("FAIL reset_hold cycle %0d: led/busy/pend=%b required 0000", i, {led, busy, pend});
            else
                n_pass++;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({led, busy, pend} !== 4'b1100)
            $display("FAIL reset_first_event: led/busy/pend=%b required 1100", {led, busy, pend});
        else
            n_pass++;
        event_i = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        clear_stim();
        ev[10] = 1'b1;
        run_trace(40);
        for (int c = 1; c <= 40; c++) begin
            logic [3:0] exp_v;
            exp_v = {(c >= 11 && c <= 18), (c >= 11 && c <= 30), 2'd0};
            n_checks++;
            if ({led_tr[c], busy_tr[c], pend_tr[c]} !== exp_v)
                $display("FAIL single cycle %0d: led/busy/pend=%b required %b", c, {led_tr[c], busy_tr[c], pend_tr[c]}, exp_v);
            else
                n_pass++;
        end
    endtask

    task automatic test_queue();
        do_reset();
        clear_stim();
        ev[10] = 1'b1;
        ev[13] = 1'b1;
        ev[15] = 1'b1;
        run_trace(80);
        for (int c = 1; c <= 80; c++) begin
            logic       el, eb;
            logic [1:0] ep;
`ifdef LED_PULSE_QUEUE_EN
            el = (c >= 11 && c <= 18) || (c >= 31 && c <= 38) || (c >= 51 && c <= 58);
            eb = (c >= 11 && c <= 70);
            ep = (c >= 51) ? 2'd0 : (c >= 31) ? 2'd1 : (c >= 16) ? 2'd2 : (c >= 14) ? 2'd1 : 2'd0;
`else
            el = (c >= 11 && c <= 18);
            eb = (c >= 11 && c <= 30);
            ep = 2'd0;
`endif
            n_checks++;
            if ({led_tr[c], busy_tr[c], pend_tr[c]} !== {el, eb, ep})
                $display("FAIL queue cycle %0d: led/busy/pend=%b required %b", c, {led_tr[c], busy_tr[c], pend_tr[c]}, {el, eb, ep});
            else
                n_pass++;
        end
    endtask

    task automatic test_saturation();
        int rises;
        int exp_rises;
        do_reset();
        clear_stim();
        ev[10] = 1'b1;
        for (int c = 12; c <= 16; c++) ev[c] = 1'b1;
        run_trace(110);
        rises = 0;
        for (int c = 1; c <= 110; c++) begin
            logic       el, eb;
            logic [1:0] ep;
`ifdef LED_PULSE_QUEUE_EN
            el = (c >= 11 && c <= 78) && (((c - 11) % 20) < 8);
            eb = (c >= 11 && c <= 90);
            ep = (c >= 71) ? 2'd0 : (c >= 51) ? 2'd1 : (c >= 31) ? 2'd2 :
                 (c >= 15) ? 2'd3 : (c >= 14) ? 2'd2 : (c >= 13) ? 2'd1 : 2'd0;
`else
            el = (c >= 11 && c <= 18);
            eb = (c >= 11 && c <= 30);
            ep = 2'd0;
`endif
            if (c >= 2 && led_tr[c] === 1'b1 && led_tr[c-1] === 1'b0) rises++;
            n_checks++;
            if ({led_tr[c], busy_tr[c], pend_tr[c]} !== {el, eb, ep})
                $display("FAIL saturation cycle %0d: led/busy/pend=%b required %b", c, {led_tr[c], busy_tr[c], pend_tr[c]}, {el, eb, ep});
            else
                n_pass++;
        end
`ifdef LED_PULSE_QUEUE_EN
        exp_rises = 4;
`else
        exp_rises = 1;
`endif
        n_checks++;
        if (rises !== exp_rises)
            $display("FAIL saturation_blinks: counted %0d blinks required %0d", rises, exp_rises);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_stim();
        ev[10] = 1'b1;
        ev[30] = 1'b1;
        run_trace(60);
        for (int c = 1; c <= 60; c++) begin
            logic [3:0] exp_v;
            exp_v = {((c >= 11 && c <= 18) || (c >= 31 && c <= 38)), (c >= 11 && c <= 50), 2'd0};
            n_checks++;
            if ({led_tr[c], busy_tr[c], pend_tr[c]} !== exp_v)
                $display("FAIL back_to_back cycle %0d: led/busy/pend=%b required %b", c, {led_tr[c], busy_tr[c], pend_tr[c]}, exp_v);
            else
                n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        clear_stim();
        ev[10] = 1'b1;
        ev[12] = 1'b1;
        ev[13] = 1'b1;
        rs[14] = 1'b1;
        run_trace(60);
        for (int c = 1; c <= 60; c++) begin
            logic       el, eb;
            logic [1:0] ep;
            el = (c >= 11 && c <= 14);
            eb = (c >= 11 && c <= 14);
`ifdef LED_PULSE_QUEUE_EN
            ep = (c == 14) ? 2'd2 : (c == 13) ? 2'd1 : 2'd0;
`else
            ep = 2'd0;
`endif
            n_checks++;
            if ({led_tr[c], busy_tr[c], pend_tr[c]} !== {el, eb, ep})
                $display("FAIL mid_reset cycle %0d: led/busy/pend=%b required %b", c, {led_tr[c], busy_tr[c], pend_tr[c]}, {el, eb, ep});
            else
                n_pass++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        event_i = 1'b0;
        test_reset();
        test_single();
        test_queue();
        test_saturation();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
